// File: rtl/coherent_frame_replay_pkg.sv
// coherent_frame_replay_pkg: shared constants and state encoding for the frame replay block
package coherent_frame_replay_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int BUF_TAM_DEF = 2048;
  localparam int SHIFT_W     = 5;
  localparam int CNT_W       = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REPLAY  = 2'd2,
    FINISH  = 2'd3
  } state_t;
endpackage

// File: rtl/coherent_frame_replay_frame_buffer_ram.sv
// frame_buffer_ram: simple dual-port sample buffer with one write port and one registered read port
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata valid one cycle after re.
module frame_buffer_ram
  import coherent_frame_replay_pkg::*;
#(
  parameter int DEPTH = BUF_TAM_DEF,
  parameter int W     = DATA_W_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/coherent_frame_replay.sv
// coherent_frame_replay: captures one averaged signal cycle and replays it R times, scaled, on a ready/valid stream
// Ports: clk, reset_n (sync, active-low); enable starts a run from IDLE; ptos_x_ciclo/repeticiones/shift_norm
// configure M, R and the output shift; data_in_valid/data_in input stream (no backpressure);
// data_out_valid/data_out_ready/data_out output stream; busy in CAPTURE/REPLAY; done in FINISH.
module coherent_frame_replay
  import coherent_frame_replay_pkg::*;
#(
  parameter int BUF_TAM = BUF_TAM_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [CNT_W-1:0]   ptos_x_ciclo,
  input  logic [CNT_W-1:0]   repeticiones,
  input  logic [SHIFT_W-1:0] shift_norm,
  input  logic               data_in_valid,
  input  logic [DATA_W-1:0]  data_in,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy,
  output logic               done
);
  localparam int AW = $clog2(BUF_TAM);
  state_t state_q, state_d;
  logic in_valid_q;
  logic [DATA_W-1:0] in_data_q;
  logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, m_last_q, m_last_d;
  logic [CNT_W-1:0] rep_q, rep_d, r_last_q, r_last_d;
  logic [SHIFT_W-1:0] sh_q, sh_d;
  logic rd_done_q, rd_done_d, pend_q, pend_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [DATA_W-1:0] ram_rd, scaled;
  logic [CNT_W-1:0] m_eff;
  logic [1:0] occ;
  logic we, issue, xfer, load;
  assign m_eff  = (ptos_x_ciclo > CNT_W'(BUF_TAM)) ? CNT_W'(BUF_TAM) : ptos_x_ciclo;
  assign scaled = $signed(ram_rd) >>> sh_q;
  assign xfer   = out_v_q & data_out_ready;
  assign load   = ~out_v_q | xfer;
  // Samples held in the output register, the skid register and the read in flight; a new read is
  // only issued if it will still have a slot when its data lands, so nothing is ever dropped.
  assign occ    = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, pend_q};
  assign issue  = (state_q == REPLAY) & ~rd_done_q & (occ <= {1'b0, xfer} + 2'd1);
  assign we     = (state_q == CAPTURE) & in_valid_q;
  frame_buffer_ram #(.DEPTH(BUF_TAM), .W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_idx_q),
    .wdata (in_data_q),
    .re    (issue),
    .raddr (rd_idx_q),
    .rdata (ram_rd)
  );
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    rep_d       = rep_q;
    rd_done_d   = rd_done_q;
    m_last_d    = m_last_q;
    r_last_d    = r_last_q;
    sh_d        = sh_q;
    pend_d      = 1'b0;
    out_v_d     = 1'b0;
    out_data_d  = out_data_q;
    skid_v_d    = 1'b0;
    skid_data_d = skid_data_q;
    case (state_q)
      IDLE: if (enable) begin
        state_d  = (m_eff == '0 || repeticiones == '0) ? FINISH : CAPTURE;
        m_last_d = AW'(m_eff - CNT_W'(1));
        r_last_d = repeticiones - CNT_W'(1);
        sh_d     = shift_norm;
      end
      CAPTURE: if (in_valid_q) begin
        wr_idx_d = (wr_idx_q == m_last_q) ? '0 : wr_idx_q + AW'(1);
        state_d  = (wr_idx_q == m_last_q) ? REPLAY : CAPTURE;
      end
      REPLAY: begin
        pend_d = issue;
        if (issue) begin
          rd_idx_d  = (rd_idx_q == m_last_q) ? '0 : rd_idx_q + AW'(1);
          rep_d     = (rd_idx_q == m_last_q) ? rep_q + CNT_W'(1) : rep_q;
          rd_done_d = (rd_idx_q == m_last_q) & (rep_q == r_last_q);
        end
        // Output register refills from the skid first (older sample), then from the RAM; a RAM word
        // that cannot go to the output parks in the skid.
        out_v_d     = load ? (skid_v_q | pend_q) : 1'b1;
        out_data_d  = (load & skid_v_q) ? skid_data_q : (load & pend_q) ? scaled : out_data_q;
        skid_v_d    = load ? (skid_v_q & pend_q) : (skid_v_q | pend_q);
        skid_data_d = (pend_q & (load == skid_v_q)) ? scaled : skid_data_q;
        if (xfer & rd_done_q & ~skid_v_q & ~pend_q) begin
          state_d = FINISH;
          out_v_d = 1'b0;
        end
      end
      default: state_d = FINISH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      rep_q       <= '0;
      rd_done_q   <= 1'b0;
      m_last_q    <= '0;
      r_last_q    <= '0;
      sh_q        <= '0;
      pend_q      <= 1'b0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_valid_q  <= data_in_valid;
      in_data_q   <= data_in;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      rep_q       <= rep_d;
      rd_done_q   <= rd_done_d;
      m_last_q    <= m_last_d;
      r_last_q    <= r_last_d;
      sh_q        <= sh_d;
      pend_q      <= pend_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end
  assign data_out_valid = out_v_q;
  assign data_out       = out_data_q;
  assign busy           = (state_q == CAPTURE) | (state_q == REPLAY);
  assign done           = (state_q == FINISH);
endmodule
